// File: rtl/turbo_pkg.sv
// Shared types and defaults for the turbo decoder iteration controller.
// Holds the FSM state encoding, decoder-select constants and the iteration clamp.
package turbo_pkg;

    localparam int MAX_ITER_DEF = 4;
    localparam int ITER_W_DEF   = 3;
    localparam int TIMEOUT_DEF  = 64;

    localparam logic SISO_SEL_DEC1 = 1'b0;
    localparam logic SISO_SEL_DEC2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SWAP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // A zero request still runs one iteration; anything above the ceiling is capped.
    function automatic int unsigned clamp_iter(int unsigned cfg, int unsigned max_iter);
        if (cfg == 0)
            return 1;
        else if (cfg > max_iter)
            return max_iter;
        else
            return cfg;
    endfunction

endpackage

// File: rtl/siso_watchdog.sv
// Cycle watchdog for one SISO half-iteration: cleared at start, counts while waiting.
// expired is asserted on the last allowed waiting cycle so the FSM can bail out on that edge.
module siso_watchdog
    import turbo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign expired    = enable && w_at_limit;

    // Saturates at the limit so a stalled enable cannot wrap back into range.
    always_ff @(posedge clk) begin
        if (rst || clear)
            r_cnt <= '0;
        else if (enable && !w_at_limit)
            r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: time-shares one SISO engine between the two
// constituent decoders, sequences La clear/swap, early termination and the watchdog.
module turbo_iter_ctrl
    import turbo_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_W   = ITER_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [ITER_W-1:0] cfg_max_iter,
    input  logic              cfg_early_en,
    output logic              siso_start,
    output logic              siso_sel,
    input  logic              siso_done,
    input  logic              hd_changed,
    output logic              la_clear,
    output logic              la_swap,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              early_stop,
    output logic              timeout_err,
    output logic              busy
);

    state_t            r_state;
    logic [ITER_W-1:0] r_max_lat;
    logic              r_early_lat;
    logic              r_chg_acc;

    logic [ITER_W-1:0] w_max_clamped;
    logic [ITER_W-1:0] w_iter_nxt;
    logic              w_stop_early;
    logic              w_last_iter;
    logic              w_wd_clear;
    logic              w_wd_en;
    logic              w_wd_expired;

    assign w_max_clamped = ITER_W'(clamp_iter(32'(cfg_max_iter), MAX_ITER));
    assign w_iter_nxt    = iter_count + ITER_W'(1);
    // chg_acc already covers both halves of the iteration when SWAP sees it.
    assign w_stop_early  = r_early_lat && !r_chg_acc;
    assign w_last_iter   = (w_iter_nxt == r_max_lat);
    assign w_wd_clear    = (r_state == START);
    assign w_wd_en       = (r_state == WAIT);

    siso_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_en),
        .expired (w_wd_expired)
    );

    // All outputs are registered; pulses are raised on the edge that enters their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_max_lat   <= '0;
            r_early_lat <= 1'b0;
            r_chg_acc   <= 1'b0;
            blk_ready   <= 1'b0;
            siso_start  <= 1'b0;
            siso_sel    <= SISO_SEL_DEC1;
            la_clear    <= 1'b0;
            la_swap     <= 1'b0;
            out_valid   <= 1'b0;
            iter_count  <= '0;
            early_stop  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            siso_start <= 1'b0;
            la_clear   <= 1'b0;
            la_swap    <= 1'b0;

            case (r_state)
                IDLE: begin
                    blk_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (blk_valid && blk_ready) begin
                        r_max_lat   <= w_max_clamped;
                        r_early_lat <= cfg_early_en;
                        r_chg_acc   <= 1'b0;
                        iter_count  <= '0;
                        early_stop  <= 1'b0;
                        timeout_err <= 1'b0;
                        siso_sel    <= SISO_SEL_DEC1;
                        la_clear    <= 1'b1;
                        blk_ready   <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end

                CLEAR: begin
                    siso_start <= 1'b1;
                    r_state    <= START;
                end

                START: begin
                    r_state <= WAIT;
                end

                WAIT: begin
                    if (siso_done) begin
                        r_chg_acc <= r_chg_acc | hd_changed;
                        la_swap   <= 1'b1;
                        r_state   <= SWAP;
                    end else if (w_wd_expired) begin
                        timeout_err <= 1'b1;
                        blk_ready   <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                SWAP: begin
                    if (siso_sel == SISO_SEL_DEC1) begin
                        siso_sel   <= SISO_SEL_DEC2;
                        siso_start <= 1'b1;
                        r_state    <= START;
                    end else begin
                        iter_count <= w_iter_nxt;
                        if (w_stop_early || w_last_iter) begin
                            early_stop <= w_stop_early && (w_iter_nxt < r_max_lat);
                            out_valid  <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            siso_sel   <= SISO_SEL_DEC1;
                            r_chg_acc  <= 1'b0;
                            siso_start <= 1'b1;
                            r_state    <= START;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomized scoreboard bench for turbo_iter_ctrl with a behavioural SISO engine.
// Drivers change inputs 1 time unit after posedge; the monitor samples on negedge.
module tb_turbo_iter_ctrl;

    localparam int MAX_ITER = 4;
    localparam int ITER_W   = 3;
    localparam int TIMEOUT  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              blk_valid = 1'b0;
    logic              blk_ready;
    logic [ITER_W-1:0] cfg_max_iter = '0;
    logic              cfg_early_en = 1'b0;
    logic              siso_start;
    logic              siso_sel;
    logic              siso_done = 1'b0;
    logic              hd_changed = 1'b0;
    logic              la_clear;
    logic              la_swap;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ITER_W-1:0] iter_count;
    logic              early_stop;
    logic              timeout_err;
    logic              busy;

    turbo_iter_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .cfg_max_iter(cfg_max_iter), .cfg_early_en(cfg_early_en),
        .siso_start(siso_start), .siso_sel(siso_sel), .siso_done(siso_done),
        .hd_changed(hd_changed), .la_clear(la_clear), .la_swap(la_swap),
        .out_valid(out_valid), .out_ready(out_ready), .iter_count(iter_count),
        .early_stop(early_stop), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // kind 0 = delivered block, 1 = watchdog abort
    typedef struct {
        int kind;
        int lat;
        int iters;
        int es;
        int starts;
        int swaps;
    } exp_t;
    exp_t sb[$];

    // Reference: walk iterations/halves by the decoding rules and derive counts and latency.
    function automatic exp_t model(int cfg, int early, int L, int tk, logic [15:0] hd);
        exp_t e;
        int   mx;
        bit   chg;
        mx = (cfg == 0) ? 1 : ((cfg > MAX_ITER) ? MAX_ITER : cfg);
        e = '{0, 0, 0, 0, 0, 0};
        for (int it = 0; it < mx; it++) begin
            chg = 1'b0;
            for (int h = 0; h < 2; h++) begin
                int idx;
                idx = 2 * it + h;
                if (idx == tk) begin
                    e.kind = 1; e.starts = idx + 1; e.swaps = idx;
                    e.lat = 2 + idx * (L + 2) + TIMEOUT + 1;
                    return e;
                end
                chg |= hd[idx];
            end
            if ((early != 0 && !chg) || it + 1 == mx) begin
                e.iters = it + 1;
                e.es = (early != 0 && !chg && it + 1 < mx) ? 1 : 0;
                e.starts = 2 * (it + 1); e.swaps = e.starts;
                e.lat = 2 + (it + 1) * 2 * (L + 2);
                return e;
            end
        end
        return e;
    endfunction

    // Engine plan for the block in flight (copied from nxt_* at accept).
    int          nxt_L = 1, nxt_tk = -1, cur_L = 1, cur_tk = -1;
    logic [15:0] nxt_hd = '0, cur_hd = '0;

    int pend = 0, eidx = 0, didx = 0;
    always begin
        @(posedge clk); #1;
        siso_done  = 1'b0;
        hd_changed = 1'($urandom_range(1, 0));
        if (la_clear) eidx = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                siso_done  = 1'b1;
                hd_changed = cur_hd[didx];
            end
        end
        if (siso_start) begin
            if (eidx != cur_tk) pend = cur_L;
            didx = eidx;
            eidx++;
        end
    end

    int stall = 0, ovr = 0;
    bit ovp = 1'b0;
    always begin
        @(posedge clk); #1;
        if (out_valid && !ovp) begin
            ovr++;
            stall = (ovr % 3 == 1) ? 20 : 0;
        end
        ovp = out_valid;
        if (stall > 0) begin
            stall--;
            out_ready = 1'b0;
        end else begin
            out_ready = 1'($urandom_range(1, 0));
        end
    end

    int   t_acc = 0, mstarts = 0, mswaps = 0, mclears = 0;
    bit   acc_prev = 0, hs_prev = 0, ov_prev = 0, te_prev = 0;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            acc_prev = 0; hs_prev = 0; ov_prev = 0; te_prev = 0;
            mstarts = 0; mswaps = 0; mclears = 0;
        end else begin
            if (acc_prev) begin
                chk("timeout_err_cleared_at_accept", int'(timeout_err), 0);
                chk("la_clear_at_T+1", int'(la_clear), 1);
            end
            if (hs_prev) begin
                chk("blk_ready_after_handshake", int'(blk_ready), 1);
                chk("out_valid_dropped", int'(out_valid), 0);
            end
            if (siso_start) begin
                chk("start_sel", int'(siso_sel), mstarts % 2);
                mstarts++;
            end
            if (siso_done && busy) chk("sel_stable_at_done", int'(siso_sel), (mstarts + 1) % 2);
            if (la_swap) mswaps++;
            if (la_clear) mclears++;
            if (out_valid) chk("blk_ready_low_in_done", int'(blk_ready), 0);
            if ((out_valid && !ov_prev) || (timeout_err && !te_prev)) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("end_kind", timeout_err ? 1 : 0, e.kind);
                    chk("latency", cyc - t_acc, e.lat);
                    chk("starts", mstarts, e.starts);
                    chk("swaps", mswaps, e.swaps);
                    chk("clears", mclears, 1);
                    if (e.kind == 0) begin
                        chk("iter_count", int'(iter_count), e.iters);
                        chk("early_stop", int'(early_stop), e.es);
                    end else begin
                        chk("blk_ready_after_timeout", int'(blk_ready), 1);
                        chk("busy_after_timeout", int'(busy), 0);
                    end
                end
            end
            acc_prev = blk_valid && blk_ready;
            if (acc_prev) begin
                t_acc = cyc; mstarts = 0; mswaps = 0; mclears = 0;
            end
            hs_prev = out_valid && out_ready;
            ov_prev = out_valid;
            te_prev = timeout_err;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_blk_ready"}, int'(blk_ready), 0);
        chk({tag, "_siso_start"}, int'(siso_start), 0);
        chk({tag, "_siso_sel"}, int'(siso_sel), 0);
        chk({tag, "_la_clear"}, int'(la_clear), 0);
        chk({tag, "_la_swap"}, int'(la_swap), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_iter_count"}, int'(iter_count), 0);
        chk({tag, "_early_stop"}, int'(early_stop), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Entered and left at posedge+1; returns one cycle after the accept edge plus gap.
    task automatic run_block(input int cfg, input int early, input int L, input int tk,
                             input logic [15:0] hd, input bit push, input int gap);
        int n;
        nxt_L = L; nxt_tk = tk; nxt_hd = hd;
        cfg_max_iter = 3'(cfg);
        cfg_early_en = 1'(early);
        blk_valid = 1'b1;
        n = 0;
        while (!blk_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!blk_ready) begin
            chk("accept_wait_bound", 0, 1);
            return;
        end
        cur_L = nxt_L; cur_tk = nxt_tk; cur_hd = nxt_hd;
        if (push) sb.push_back(model(cfg, early, L, tk, hd));
        @(posedge clk); #1;
        cfg_max_iter = 3'($urandom_range(7, 0));
        cfg_early_en = 1'($urandom_range(1, 0));
        if (gap > 0) begin
            blk_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int n;
        int bad;
        bit seen_done;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("blk_ready_after_release", int'(blk_ready), 1);

        run_block(2, 0, 10, -1, 16'hFFFF, 1, 0);
        run_block(4, 1, 7, -1, 16'hFFF3, 1, 0);
        run_block(2, 1, 5, -1, 16'hFFF3, 1, 2);
        run_block(3, 0, 5, 0, 16'hFFFF, 1, 0);
        run_block(2, 0, 3, -1, 16'hFFFF, 1, 0);
        run_block(3, 0, 4, 3, 16'hFFFF, 1, 0);
        run_block(0, 0, 4, -1, 16'hFFFF, 1, 0);
        run_block(7, 0, 3, -1, 16'hFFFF, 1, 0);
        for (int b = 0; b < 34; b++) begin
            run_block($urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(12, 1),
                      ($urandom_range(7, 0) == 0) ? $urandom_range(7, 0) : -1,
                      16'($urandom), 1,
                      ($urandom_range(3, 0) == 0) ? $urandom_range(5, 1) : 0);
        end
        blk_valid = 1'b0;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_complete", (sb.size() == 0 && !busy) ? 1 : 0, 1);

        // Abort mid-WAIT; the engine's pending done then lands after release.
        run_block(4, 0, 40, -1, 16'hFFFF, 0, 1);
        repeat (8) begin @(posedge clk); #1; end
        chk("busy_before_reset", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_blk_ready_after_release", int'(blk_ready), 1);
        bad = 0;
        seen_done = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (siso_done) seen_done = 1'b1;
            if (siso_start || la_swap || la_clear || out_valid || busy || timeout_err || !blk_ready)
                bad++;
        end
        chk("midrst_quiet_after_release", bad, 0);
        chk("midrst_stray_done_pulsed", int'(seen_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/turbo_iter_ctrl.md
Name: turbo_iter_ctrl

Overview:
- Iteration scheduler for the turbo decoder.
- Accepts a buffered block from the input RAM/buffer stage, then time-shares one SISO engine between constituent decoder 1 (parity1, natural order) and decoder 2 (parity2, interleaved order).
- Sequences a-priori (La) clear and swap, counts iterations, applies early termination and a SISO watchdog.
- Presents the decoded block to the output stage with a valid/ready handshake.

Parameters:
- MAX_ITER, 4, hard ceiling on full iterations (one iteration = two half-iterations).
- ITER_W, 3, width of iteration fields; must satisfy 2^ITER_W > MAX_ITER.
- TIMEOUT, 64, cycles allowed in WAIT before siso_done must arrive.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- blk_valid  in  1  input buffer holds a complete block
- blk_ready  out  1  controller can accept a block
- cfg_max_iter  in  ITER_W  iteration limit; sampled at accept
- cfg_early_en  in  1  enable early termination; sampled at accept
- siso_start  out  1  one-cycle start pulse to SISO engine
- siso_sel  out  1  0 = decoder 1, 1 = decoder 2; stable from START through WAIT
- siso_done  in  1  one-cycle completion pulse from engine
- hd_changed  in  1  engine flag: any hard decision changed this half-iteration; valid with siso_done
- la_clear  out  1  one-cycle pulse: zero La buffer
- la_swap  out  1  one-cycle pulse: commit extrinsic as next La
- out_valid  out  1  decoded block available
- out_ready  in  1  output stage accepts
- iter_count  out  ITER_W  completed full iterations for current block
- early_stop  out  1  current/last block terminated early
- timeout_err  out  1  sticky watchdog error
- busy  out  1  state != IDLE

Behaviour:
- Clock domain and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0 except blk_ready; state IDLE; chg_acc = 0.
  - blk_ready is a registered decode of IDLE, so it reads 0 during the reset cycle and 1 the cycle after reset releases.
  - Reset mid-operation aborts immediately; no siso_start or la_* pulse is emitted in the cycle after rst.
- States: IDLE, CLEAR, START, WAIT, SWAP, DONE.
- IDLE:
  - blk_ready = 1.
  - On blk_valid && blk_ready at cycle T: latch max_lat = clamp(cfg_max_iter, 1, MAX_ITER), early_lat = cfg_early_en.
  - Clear iter_count, early_stop, timeout_err and chg_acc; siso_sel <= 0; go to CLEAR.
- CLEAR (T+1): la_clear = 1; go to START.
- START (T+2 on first pass):
  - siso_start = 1 for exactly one cycle.
  - Watchdog counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On siso_done at cycle D: chg_acc |= hd_changed; go to SWAP.
  - If the counter reaches TIMEOUT-1 without siso_done: timeout_err <= 1 (sticky until next accept); go to IDLE; no out_valid.
  - siso_done in any state other than WAIT is ignored.
- SWAP (D+1): la_swap = 1.
  - If siso_sel = 0: siso_sel <= 1; go to START.
  - If siso_sel = 1:
    - iter_count <= iter_count + 1 (visible D+2).
    - stop_early = early_lat && !chg_acc.
    - If stop_early or iter_count+1 == max_lat: early_stop <= stop_early and (iter_count+1 < max_lat); go to DONE.
    - Else: siso_sel <= 0, chg_acc <= 0; go to START.
- DONE: out_valid = 1, held until out_ready; on handshake go to IDLE.
- Not-ready conditions:
  - out_ready while not in DONE: ignored.
  - blk_valid while not in IDLE: not accepted, because blk_ready = 0.
- Decode cycle count, when the engine takes L cycles from start to done: 2 + max_lat·2·(L+2) cycles from accept to out_valid.

Decomposition:
- Shared package turbo_pkg holds:
  - state enum: IDLE, CLEAR, START, WAIT, SWAP, DONE
  - SISO_SEL_DEC1 = 0, SISO_SEL_DEC2 = 1
  - default ITER_W, MAX_ITER, TIMEOUT
- One sub-module: siso_watchdog.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT.
  - Counter width = $clog2(TIMEOUT).

Test Plan:
1. max_iter=2, early off, engine done 10 cycles after each start, hd_changed=1 → four siso_start pulses with sel 0,1,0,1; four la_swap; one la_clear at T+1; iter_count=2; out_valid at T+2+2·2·12 = T+50; early_stop=0.
2. max_iter=4, early on, hd_changed=1 in iteration 1 and 0 in both halves of iteration 2 → exactly 4 starts; iter_count=2; early_stop=1; out_valid asserted.
3. TIMEOUT=64, engine never responds → timeout_err=1 and state IDLE 64 cycles after entering WAIT, blk_ready=1; next accept clears timeout_err.
4. out_ready low 20 cycles in DONE with blk_valid=1 → out_valid held, blk_ready=0, no accept; handshake, then accept on the following cycle.
5. cfg_max_iter=0 → 1 iteration (2 starts, iter_count=1); cfg_max_iter=7 with MAX_ITER=4 → 8 starts, iter_count=4.
6. rst asserted mid-WAIT, then siso_done pulsed after release → all outputs at reset values, blk_ready=1 one cycle after release; no la_swap or start, siso_done ignored.
